// File: rtl/sequencer.sv
// Command sequencer: consumes 64-bit command words from a from-PC FIFO and
// produces echo, ramp and status words into a to-PC FIFO under backpressure.
module sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        fpc_valid,
    input  logic [63:0] fpc_data,
    output logic        fpc_read,
    input  logic        tpc_ready,
    output logic        tpc_write,
    output logic [63:0] tpc_data
);

    typedef enum logic [1:0] {IDLE, ECHO, RAMP, STATUS} state_t;

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_ECHO    = 8'h01;
    localparam logic [7:0] OP_RAMP    = 8'h02;
    localparam logic [7:0] OP_SETBASE = 8'h03;
    localparam logic [7:0] OP_STATUS  = 8'h04;

    state_t      state_reg, state_next;
    logic [63:0] base_reg, base_next;
    logic [63:0] value_reg, value_next;
    logic [31:0] remaining_reg, remaining_next;
    logic [31:0] cmd_count_reg, cmd_count_next;
    logic [31:0] err_count_reg, err_count_next;
    logic [63:0] out_reg, out_next;
    logic [7:0]  opcode;

    assign opcode = fpc_data[63:56];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            value_reg     <= '0;
            remaining_reg <= '0;
            cmd_count_reg <= '0;
            err_count_reg <= '0;
            out_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            value_reg     <= value_next;
            remaining_reg <= remaining_next;
            cmd_count_reg <= cmd_count_next;
            err_count_reg <= err_count_next;
            out_reg       <= out_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        value_next     = value_reg;
        remaining_next = remaining_reg;
        cmd_count_next = cmd_count_reg;
        err_count_next = err_count_reg;
        out_next       = out_reg;

        // Gated by reset so both handshakes are quiet while reset is held.
        fpc_read  = reset && fpc_valid && (state_reg == IDLE);
        tpc_write = reset && tpc_ready && (state_reg != IDLE);
        tpc_data  = (state_reg == RAMP) ? value_reg : out_reg;

        case (state_reg)
            IDLE: begin
                if (fpc_read) begin
                    cmd_count_next = cmd_count_reg + 32'd1;
                    case (opcode)
                        OP_NOP: ;
                        OP_ECHO: begin
                            out_next   = fpc_data;
                            state_next = ECHO;
                        end
                        OP_SETBASE: base_next = {8'h00, fpc_data[55:0]};
                        OP_RAMP: begin
                            remaining_next = fpc_data[31:0];
                            value_next     = base_reg;
                            if (fpc_data[31:0] != 32'd0)
                                state_next = RAMP;
                        end
                        OP_STATUS: begin
                            out_next   = {8'hA5, 24'h0, cmd_count_reg};
                            state_next = STATUS;
                        end
                        default: err_count_next = err_count_reg + 32'd1;
                    endcase
                end
            end
            ECHO, STATUS: begin
                if (tpc_ready)
                    state_next = IDLE;
            end
            RAMP: begin
                if (tpc_ready) begin
                    value_next     = value_reg + 64'd1;
                    remaining_next = remaining_reg - 32'd1;
                    if (remaining_reg == 32'd1)
                        state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sequencer.sv
// Directed bench for sequencer: each cycle drives the FIFO handshakes and
// compares fpc_read / tpc_write / tpc_data against hand-computed values.
module tb_sequencer;

    logic        clock;
    logic        reset;
    logic        fpc_valid;
    logic [63:0] fpc_data;
    logic        fpc_read;
    logic        tpc_ready;
    logic        tpc_write;
    logic [63:0] tpc_data;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] NOP     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] ECHO_W  = 64'h0100_0000_DEAD_BEEF;

    sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .fpc_valid (fpc_valid),
        .fpc_data  (fpc_data),
        .fpc_read  (fpc_read),
        .tpc_ready (tpc_ready),
        .tpc_write (tpc_write),
        .tpc_data  (tpc_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then sample outputs
    // that will be acted on at the following rising edge.
    task automatic cyc(input string tag, input logic v, input logic [63:0] d, input logic r,
                       input logic exp_read, input logic exp_write, input logic [63:0] exp_data);
        @(negedge clock);
        fpc_valid = v;
        fpc_data  = d;
        tpc_ready = r;
        #1;
        $display("%-14s valid=%0b ready=%0b read=%0b write=%0b data=%h",
                 tag, v, r, fpc_read, tpc_write, tpc_data);
        check({tag, " read"}, {63'h0, fpc_read}, {63'h0, exp_read});
        check({tag, " write"}, {63'h0, tpc_write}, {63'h0, exp_write});
        if (exp_write)
            check({tag, " data"}, tpc_data, exp_data);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset     = 1'b0;
        fpc_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    logic       bp_ready [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] bp_expect;

    initial begin
        reset     = 1'b0;
        fpc_valid = 1'b1;
        fpc_data  = ECHO_W;
        tpc_ready = 1'b1;
        #2;
        check("reset read", {63'h0, fpc_read}, 64'h0);
        check("reset write", {63'h0, tpc_write}, 64'h0);
        check("reset data", tpc_data, 64'h0);
        fpc_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        // Echo: one write, one cycle after the read
        cyc("echo acc",   1'b1, ECHO_W, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("echo wr",    1'b0, NOP,    1'b1, 1'b0, 1'b1, ECHO_W);
        cyc("echo done",  1'b0, NOP,    1'b1, 1'b0, 1'b0, 64'h0);

        // Ramp of 3 from base 0x10; next command waiting is held off until done
        cyc("setbase",    1'b1, 64'h0300_0000_0000_0010, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("ramp acc",   1'b1, 64'h0200_0000_0000_0003, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("ramp w0",    1'b1, NOP, 1'b1, 1'b0, 1'b1, 64'h10);
        cyc("ramp w1",    1'b1, NOP, 1'b1, 1'b0, 1'b1, 64'h11);
        cyc("ramp w2",    1'b1, NOP, 1'b1, 1'b0, 1'b1, 64'h12);
        cyc("ramp next",  1'b1, NOP, 1'b1, 1'b1, 1'b0, 64'h0);

        // Repeated ramp restarts from the unchanged base
        cyc("reramp acc", 1'b1, 64'h0200_0000_0000_0001, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("reramp w0",  1'b0, NOP, 1'b1, 1'b0, 1'b1, 64'h10);

        // Wrap: base top byte is cleared, increment carries into bit 56
        cyc("setbase ff", 1'b1, 64'h03FF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("wrap acc",   1'b1, 64'h0200_0000_0000_0002, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("wrap w0",    1'b0, NOP, 1'b1, 1'b0, 1'b1, 64'h00FF_FFFF_FFFF_FFFF);
        cyc("wrap w1",    1'b0, NOP, 1'b1, 1'b0, 1'b1, 64'h0100_0000_0000_0000);
        cyc("wrap done",  1'b0, NOP, 1'b1, 1'b0, 1'b0, 64'h0);

        // Zero-count ramp: no output, next word read straight away
        cyc("zero acc",   1'b1, 64'h0200_0000_0000_0000, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("zero next",  1'b1, NOP, 1'b1, 1'b1, 1'b0, 64'h0);

        // Backpressure: ramp of 4 from 0x20 under a toggling ready
        cyc("bp base",    1'b1, 64'h0300_0000_0000_0020, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("bp acc",     1'b1, 64'h0200_0000_0000_0004, 1'b1, 1'b1, 1'b0, 64'h0);
        bp_expect = 64'h20;
        for (int i = 0; i < 7; i++) begin
            cyc($sformatf("bp c%0d", i), 1'b1, NOP, bp_ready[i], 1'b0, bp_ready[i], bp_expect);
            if (bp_ready[i])
                bp_expect = bp_expect + 64'd1;
        end
        cyc("bp next",    1'b1, NOP, 1'b1, 1'b1, 1'b0, 64'h0);

        // Status counts NOP and unknown opcodes, sampled before increment
        pulse_reset();
        cyc("st nop0",    1'b1, NOP, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("st bad",     1'b1, 64'h7F00_0000_0000_0000, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("st nop1",    1'b1, NOP, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("st acc",     1'b1, 64'h0400_0000_0000_0000, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("st stall",   1'b1, NOP, 1'b0, 1'b0, 1'b0, 64'h0);
        cyc("st wr",      1'b1, NOP, 1'b1, 1'b0, 1'b1, 64'hA500_0000_0000_0003);
        cyc("st next",    1'b0, NOP, 1'b1, 1'b0, 1'b0, 64'h0);

        // Reset abort mid-ramp
        pulse_reset();
        cyc("ab acc",     1'b1, 64'h0200_0000_0000_000A, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("ab w0",      1'b1, NOP, 1'b1, 1'b0, 1'b1, 64'h0);
        cyc("ab w1",      1'b1, NOP, 1'b1, 1'b0, 1'b1, 64'h1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        $display("abort         read=%0b write=%0b data=%h", fpc_read, tpc_write, tpc_data);
        check("abort write", {63'h0, tpc_write}, 64'h0);
        check("abort read", {63'h0, fpc_read}, 64'h0);
        check("abort data", tpc_data, 64'h0);
        fpc_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        cyc("ab idle",    1'b0, NOP, 1'b1, 1'b0, 1'b0, 64'h0);
        cyc("ab st acc",  1'b1, 64'h0400_0000_0000_0000, 1'b1, 1'b1, 1'b0, 64'h0);
        cyc("ab st wr",   1'b0, NOP, 1'b1, 1'b0, 1'b1, 64'hA500_0000_0000_0000);
        cyc("ab done",    1'b0, NOP, 1'b1, 1'b0, 1'b0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sequencer.md
SEQUENCER -- requirements
Module: sequencer

Interface
REQ-001 clock  input  1  sole clock; all state changes on its rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 fpc_valid  input  1  from-PC FIFO holds a word; fpc_data is valid while high (first-word-fall-through).
REQ-004 fpc_data  input  64  current from-PC word; opcode in [63:56].
REQ-005 fpc_read  output  1  consumes the current from-PC word this cycle.
REQ-006 tpc_ready  input  1  to-PC FIFO can accept a word this cycle.
REQ-007 tpc_write  output  1  writes tpc_data into the to-PC FIFO this cycle.
REQ-008 tpc_data  output  64  to-PC word, meaningful only while tpc_write is high.
REQ-009 No parameters.

Function
REQ-010 States: IDLE, ECHO, RAMP, STATUS.
REQ-011 fpc_read is combinational: it equals fpc_valid AND (state == IDLE).
REQ-012 The word is decoded on the cycle fpc_read is high.
REQ-013 tpc_write is asserted only in a cycle where tpc_ready is high; it is never high in IDLE.
REQ-014 Each write transfers exactly one word.
REQ-015 Opcode 0x00 NOP: no output; stay IDLE.
REQ-016 Opcode 0x01 ECHO: latch the full 64-bit word into the output register; go to ECHO.
REQ-017 ECHO: write the latched word on the first cycle tpc_ready is high, then return to IDLE.
REQ-018 Opcode 0x03 SETBASE: base register <= {8'h00, fpc_data[55:0]}; no output; stay IDLE.
REQ-019 Opcode 0x02 RAMP: remaining <= fpc_data[31:0] and value <= base. If fpc_data[31:0] == 0, stay IDLE with no output; otherwise go to RAMP.
REQ-020 RAMP: each cycle with tpc_ready high, write value, then value <= value+1 (64-bit, wraps modulo 2^64) and remaining <= remaining-1.
REQ-021 RAMP: the cycle that writes the last word (remaining == 1) returns to IDLE.
REQ-022 Opcode 0x04 STATUS: latch {8'hA5, 24'h0, cmd_count[31:0]}, with cmd_count sampled before this command increments it; go to STATUS.
REQ-023 STATUS: write the latched word on the first cycle tpc_ready is high, then return to IDLE.
REQ-024 Any other opcode: increment err_count (32-bit); no output; stay IDLE.
REQ-025 cmd_count (32-bit, wraps) increments on every fpc_read cycle, including NOP and unknown opcodes.
REQ-026 Stall: while tpc_ready is low, the state and all pending data/counters hold unchanged; no word is lost or duplicated.
REQ-027 One new command word can be accepted in the cycle after the final write of the previous command.
REQ-028 The base register is not modified by RAMP; a repeated RAMP restarts from the same base.

Reset
REQ-029 When reset goes low: state=IDLE, base=0, value=0, remaining=0, cmd_count=0, err_count=0, output register=0.
REQ-030 During reset, fpc_read=0 and tpc_write=0; tpc_data=0.
REQ-031 Reset asserted mid-ECHO, mid-RAMP or mid-STATUS aborts the command immediately; no further writes occur.
REQ-032 After reset deasserts, the first command is accepted on the first rising edge where fpc_valid is high.

Verification
REQ-033 ECHO: push 0x0100_0000_DEAD_BEEF with tpc_ready=1 -> exactly one write of 0x0100_0000_DEAD_BEEF, one cycle after the read.
REQ-034 RAMP: push SETBASE 0x0300_0000_0000_0010, then RAMP 0x0200_0000_0000_0003 -> writes 0x10, 0x11, 0x12 on consecutive cycles, then IDLE.
REQ-035 RAMP wrap and zero-count cases:
- SETBASE 0x03FF_FFFF_FFFF_FFFF then RAMP count 2 -> writes 0x00FF_FFFF_FFFF_FFFF, then 0x0100_0000_0000_0000.
- RAMP count 0 -> no write; the next word is read on the following cycle.
REQ-036 Backpressure: RAMP count 4 with tpc_ready toggling 1,0,0,1,1,0,1 -> exactly 4 writes (values base..base+3, in order).
- No write occurs while tpc_ready=0.
- fpc_read stays low until the last write.
REQ-037 STATUS: after reset, push NOP, 0x7F00_..., NOP, then STATUS -> one write of 0xA500_0000_0000_0003.
REQ-038 Reset abort: assert reset after 2 of 10 RAMP words have been written -> tpc_write=0 immediately; after release, STATUS reports a count of 0.
